gf_seq_mult: RTL

Multi-cycle, digit-serial multiplier for the GF(2^m) operations library. Supports integer (carry) and carry-less products, squaring, and reduction modulo a runtime-selected primitive polynomial of degree 2..DATA_WIDTH. It is the sequential successor to the single-cycle combinational multiplier/reducer array. It trades latency for area by processing DIGIT_WIDTH multiplier bits per cycle behind a valid/ready handshake.

---
 rtl/gf_ops_pkg.sv | 39 +++
 rtl/gf_digit_step.sv | 88 ++++++++
 rtl/gf_seq_mult.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/gf_ops_pkg.sv
// Shared types and sizing helpers for the GF(2^m) operations library.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gf_ops_pkg;

    // Default operand and digit widths used by the sequential multiplier.
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_DIGIT_WIDTH = 4;

    // Multiply-phase step count (W/D) and accumulator width (2W) for the defaults.
    localparam int DEF_MULT_STEPS  = DEF_DATA_WIDTH / DEF_DIGIT_WIDTH;
    localparam int DEF_ACC_WIDTH   = 2 * DEF_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MULT   = 2'd1,
        ST_REDUCE = 2'd2,
        ST_DONE   = 2'd3
    } gf_state_e;

    // Number of digit steps needed to consume a W-bit multiplier.
    function automatic int mult_steps(input int w, input int d);
        return w / d;
    endfunction

    // Width of the double-length product accumulator.
    function automatic int acc_width(input int w);
        return 2 * w;
    endfunction

    // Reduce-phase cycles: bits 2m-2 .. m (m-1 bits) eliminated d per cycle.
    function automatic int reduce_steps(input int m, input int d);
        if (m < 2) begin
            return 0;
        end
        return (m - 1 + d - 1) / d;
    endfunction

endpackage

// File: rtl/gf_digit_step.sv
// One digit step of the sequential GF multiplier: multiply-accumulate or D-bit reduction.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
//
// Ports:
//   acc_i/acc_o  current / next 2W-bit accumulator
//   a_i, digit_i multiplicand and the D-bit multiplier digit for this step
//   step_i       digit index; the partial product is shifted by D*step_i
//   carry_i      1 = integer add, 0 = carry-less (xor) accumulate
//   reduce_i     1 = eliminate D high bits against poly_i instead of multiplying
//   poly_i, m_i  reduction polynomial (bit m set, bits above m clear) and degree m
//   jtop_i       highest bit position eliminated in this reduce step
module gf_digit_step
    import gf_ops_pkg::*;
#(
    parameter int W  = DEF_DATA_WIDTH,
    parameter int D  = DEF_DIGIT_WIDTH,
    parameter int CW = $clog2(DEF_MULT_STEPS + 1),
    parameter int MW = $clog2(DEF_DATA_WIDTH) + 1,
    parameter int IW = $clog2(DEF_ACC_WIDTH) + 1
) (
    input  logic [2*W-1:0] acc_i,
    input  logic [W-1:0]   a_i,
    input  logic [D-1:0]   digit_i,
    input  logic [CW-1:0]  step_i,
    input  logic           carry_i,
    input  logic           reduce_i,
    input  logic [W:0]     poly_i,
    input  logic [MW-1:0]  m_i,
    input  logic [IW-1:0]  jtop_i,
    output logic [2*W-1:0] acc_o
);

    localparam int AW = 2 * W;

    logic [AW-1:0] pp_int;
    logic [AW-1:0] pp_clmul;
    logic [AW-1:0] pp;
    logic [AW-1:0] pp_sh;
    logic [IW-1:0] sh;
    logic [AW-1:0] red_acc;
    logic [AW-1:0] p_ext;
    logic [IW-1:0] j;

    // Carry-less partial product: xor of shifted copies of a for each set digit bit.
    always_comb begin
        pp_clmul = '0;
        for (int t = 0; t < D; t++) begin
            if (digit_i[t]) begin
                pp_clmul = pp_clmul ^ (AW'(a_i) << t);
            end
        end
    end

    assign pp_int = AW'(a_i) * AW'(digit_i);
    assign pp     = carry_i ? pp_int : pp_clmul;
    assign sh     = IW'(step_i) * IW'(D);
    assign pp_sh  = pp << sh;

    // Chained elimination, highest bit first, so a bit cleared here can no longer
    // be disturbed by later xors (poly has nothing above bit m). Positions below m
    // are skipped, which makes the final step eliminate only what is left.
    assign p_ext = AW'(poly_i);

    always_comb begin
        red_acc = acc_i;
        j       = '0;
        for (int t = 0; t < D; t++) begin
            j = jtop_i - IW'(t);
            if (jtop_i >= IW'(m_i) + IW'(t)) begin
                if (|(red_acc & (AW'(1) << j))) begin
                    red_acc = red_acc ^ (p_ext << (j - IW'(m_i)));
                end
            end
        end
    end

    always_comb begin
        if (reduce_i) begin
            acc_o = red_acc;
        end else if (carry_i) begin
            acc_o = acc_i + pp_sh;
        end else begin
            acc_o = acc_i ^ pp_sh;
        end
    end

endmodule

// File: rtl/gf_seq_mult.sv
// Digit-serial GF(2^m)/integer multiplier with optional modular reduction.
// Latency: W/D cycles, plus ceil((m-1)/D) when reducing; invalid reduction degree answers after 1 edge.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          request handshake
//   exp_funct                  square a (b ignored)
//   red_funct                  reduce modulo polyn_red_in of degree polyn_grade
//   carry_option               integer product when 1 (ignored when reducing)
//   polyn_grade, polyn_red_in  reduction degree m and polynomial
//   a, b                       operands
//   out_valid/out_ready        result handshake
//   out, mult_out, err         result low word / residue, full product, bad-degree flag
module gf_seq_mult
    import gf_ops_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DIGIT_WIDTH = DEF_DIGIT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      exp_funct,
    input  logic                      red_funct,
    input  logic                      carry_option,
    input  logic [$clog2(DATA_WIDTH):0] polyn_grade,
    input  logic [DATA_WIDTH:0]       polyn_red_in,
    input  logic [DATA_WIDTH-1:0]     a,
    input  logic [DATA_WIDTH-1:0]     b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out,
    output logic [2*DATA_WIDTH-1:0]   mult_out,
    output logic                      err
);

    localparam int W     = DATA_WIDTH;
    localparam int D     = DIGIT_WIDTH;
    localparam int STEPS = mult_steps(W, D);
    localparam int AW    = acc_width(W);
    localparam int MW    = $clog2(W) + 1;
    localparam int CW    = $clog2(STEPS + 1);
    localparam int RCW   = $clog2(W + 1);
    localparam int IW    = $clog2(AW) + 1;
    localparam int BW    = $clog2(W);

    gf_state_e      state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           carry_q, carry_d;
    logic           red_q, red_d;
    logic [MW-1:0]  m_q, m_d;
    logic [W:0]     p_q, p_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic [RCW-1:0] rlast_q, rlast_d;
    logic [IW-1:0]  jtop_q, jtop_d;
    logic [AW-1:0]  mult_q, mult_d;
    logic [W-1:0]   out_q, out_d;
    logic           err_q, err_d;

    logic           req_err;
    logic [W-1:0]   in_mask;
    logic [W-1:0]   b_src;
    logic [W-1:0]   m_mask;
    logic [BW-1:0]  digit_base;
    logic [D-1:0]   digit;
    logic [AW-1:0]  step_acc;

    // A reduction degree outside 2..W cannot be honoured; such requests skip the datapath.
    assign req_err = red_funct && ((polyn_grade < MW'(2)) || (polyn_grade > MW'(W)));

    // Low-m-bit masks; a shift by m = W yields an all-ones mask as intended.
    assign in_mask = ~({W{1'b1}} << polyn_grade);
    assign m_mask  = ~({W{1'b1}} << m_q);
    assign b_src   = exp_funct ? a : b;

    assign digit_base = BW'(cnt_q) * BW'(D);
    assign digit      = b_q[digit_base +: D];

    gf_digit_step #(
        .W  (W),
        .D  (D),
        .CW (CW),
        .MW (MW),
        .IW (IW)
    ) u_step (
        .acc_i    (acc_q),
        .a_i      (a_q),
        .digit_i  (digit),
        .step_i   (cnt_q),
        .carry_i  (carry_q),
        .reduce_i (state_q == ST_REDUCE),
        .poly_i   (p_q),
        .m_i      (m_q),
        .jtop_i   (jtop_q),
        .acc_o    (step_acc)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        red_d   = red_q;
        m_d     = m_q;
        p_d     = p_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        rlast_d = rlast_q;
        jtop_d  = jtop_q;
        mult_d  = mult_q;
        out_d   = out_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    acc_d = '0;
                    cnt_d = '0;
                    if (req_err) begin
                        state_d = ST_DONE;
                        out_d   = '0;
                        mult_d  = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_MULT;
                        a_d     = red_funct ? (a & in_mask) : a;
                        b_d     = red_funct ? (b_src & in_mask) : b_src;
                        carry_d = carry_option & ~red_funct;
                        red_d   = red_funct;
                        m_d     = polyn_grade;
                        // Only bits up to m matter and bit m is implied set.
                        p_d     = (polyn_red_in & ~({(W + 1){1'b1}} << polyn_grade))
                                | ((W + 1)'(1) << polyn_grade);
                        rlast_d = RCW'(reduce_steps(int'(polyn_grade), D) - 1);
                        err_d   = 1'b0;
                    end
                end
            end

            ST_MULT: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(STEPS - 1)) begin
                    cnt_d  = '0;
                    mult_d = step_acc;
                    if (red_q) begin
                        state_d = ST_REDUCE;
                        rcnt_d  = '0;
                        // Highest possible product bit of two degree-(m-1) operands.
                        jtop_d  = (IW'(m_q) << 1) - IW'(2);
                    end else begin
                        state_d = ST_DONE;
                        out_d   = step_acc[W-1:0];
                    end
                end
            end

            ST_REDUCE: begin
                acc_d  = step_acc;
                rcnt_d = rcnt_q + RCW'(1);
                jtop_d = jtop_q - IW'(D);
                if (rcnt_q == rlast_q) begin
                    state_d = ST_DONE;
                    out_d   = step_acc[W-1:0] & m_mask;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            red_q   <= 1'b0;
            m_q     <= '0;
            p_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            rlast_q <= '0;
            jtop_q  <= '0;
            mult_q  <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            red_q   <= red_d;
            m_q     <= m_d;
            p_q     <= p_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            rlast_q <= rlast_d;
            jtop_q  <= jtop_d;
            mult_q  <= mult_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out       = out_q;
    assign mult_out  = mult_q;
    assign err       = err_q;

endmodule
